ccsds_frame_sync_derandomizer: RTL and testbench

Receive-side counterpart of the CCSDS 131.0-B3 pseudo-randomizer. It takes a bit-serial demodulated stream and searches for the 32-bit Attached Sync Marker (ASM). Once locked, it strips the ASM and XORs each codeblock bit with the CCSDS PN sequence, reseeded per codeblock, to recover the payload. It sits between the bit-sync/demod output and the downstream frame buffer or decoder, and keeps lock with a flywheel across missed markers.

---
 rtl/ccsds_pkg.sv | 24 ++
 rtl/ccsds_pn_lfsr.sv | 36 +++
 rtl/ccsds_frame_sync_derandomizer.sv | 155 +++++++++++++++
 tb/tb_ccsds_frame_sync_derandomizer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccsds_pkg.sv
// rtl/ccsds_pkg.sv - shared constants, state type and popcount helper for CCSDS sync/PN blocks
package ccsds_pkg;

    localparam logic [31:0] ASM_DEFAULT = 32'h1ACFFC1D;
    localparam logic [7:0]  LFSR_SEED   = 8'hFF;
    // Feedback taps of x^8+x^7+x^5+x^3+1 as seen from the right-shifting register: bits 7,5,3,0
    localparam logic [7:0]  LFSR_TAPS   = 8'b1010_1001;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        FRAME  = 2'd1,
        CHECK  = 2'd2
    } sync_state_e;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/ccsds_pn_lfsr.sv
// rtl/ccsds_pn_lfsr.sv - CCSDS pseudo-randomizer PN generator, reseed has priority over step
module ccsds_pn_lfsr
    import ccsds_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic reseed_i,
    input  logic step_i,
    output logic pn_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Next LFSR value: reseed, otherwise shift right with parity feedback into bit 7
    always_comb begin
        lfsr_d = lfsr_q;
        if (reseed_i) begin
            lfsr_d = LFSR_SEED;
        end else if (step_i) begin
            lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[7:1]};
        end
    end

    // LFSR register, seeded on reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign pn_o = lfsr_q[0];

endmodule

// File: rtl/ccsds_frame_sync_derandomizer.sv
// rtl/ccsds_frame_sync_derandomizer.sv - ASM frame sync with flywheel and per-codeblock PN derandomizer
module ccsds_frame_sync_derandomizer
    import ccsds_pkg::*;
#(
    parameter logic [31:0] ASM         = ASM_DEFAULT,
    parameter int          FRAME_BITS  = 2040,
    parameter int          ASM_MAX_ERR = 2,
    parameter int          MISS_LIMIT  = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic bit_i,
    input  logic bit_valid_i,
    output logic data_o,
    output logic data_valid_o,
    output logic frame_start_o,
    output logic frame_end_o,
    output logic locked_o,
    output logic asm_miss_o
);

    localparam logic [15:0] LAST_BIT = 16'(FRAME_BITS - 1);
    localparam logic [5:0]  MAX_ERR  = 6'(ASM_MAX_ERR);
    localparam logic [3:0]  MISS_LIM = 4'(MISS_LIMIT);

    sync_state_e state_q, state_d;
    logic [31:0] asm_sr_q, asm_sr_d;
    logic [15:0] bit_cnt_q, bit_cnt_d;
    logic [4:0]  asm_cnt_q, asm_cnt_d;
    logic [3:0]  miss_cnt_q, miss_cnt_d;
    logic        data_q, data_d;
    logic        data_valid_q, data_valid_d;
    logic        frame_start_q, frame_start_d;
    logic        frame_end_q, frame_end_d;
    logic        asm_miss_q, asm_miss_d;

    logic [31:0] next_sr;
    logic        asm_match;
    logic        lfsr_reseed;
    logic        lfsr_step;
    logic        pn;

    // Match is judged on the window that already includes the bit arriving this cycle
    assign next_sr   = {asm_sr_q[30:0], bit_i};
    assign asm_match = (popcount32(next_sr ^ ASM) <= MAX_ERR);

    ccsds_pn_lfsr u_pn_lfsr (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .reseed_i (lfsr_reseed),
        .step_i   (lfsr_step),
        .pn_o     (pn)
    );

    // Sync state machine: next state, counters, LFSR control and registered output values
    always_comb begin
        state_d       = state_q;
        asm_sr_d      = asm_sr_q;
        bit_cnt_d     = bit_cnt_q;
        asm_cnt_d     = asm_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        data_d        = 1'b0;
        data_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        asm_miss_d    = 1'b0;
        lfsr_reseed   = 1'b0;
        lfsr_step     = 1'b0;

        if (bit_valid_i) begin
            asm_sr_d = next_sr;
            case (state_q)
                SEARCH: begin
                    if (asm_match) begin
                        state_d     = FRAME;
                        bit_cnt_d   = '0;
                        miss_cnt_d  = '0;
                        lfsr_reseed = 1'b1;
                    end
                end
                FRAME: begin
                    data_d        = bit_i ^ pn;
                    data_valid_d  = 1'b1;
                    frame_start_d = (bit_cnt_q == 16'd0);
                    frame_end_d   = (bit_cnt_q == LAST_BIT);
                    lfsr_step     = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = CHECK;
                        asm_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 16'd1;
                    end
                end
                CHECK: begin
                    if (asm_cnt_q == 5'd31) begin
                        if (asm_match) begin
                            miss_cnt_d = '0;
                        end else begin
                            asm_miss_d = 1'b1;
                            miss_cnt_d = miss_cnt_q + 4'd1;
                        end
                        if (!asm_match && (miss_cnt_q + 4'd1 == MISS_LIM)) begin
                            state_d = SEARCH;
                        end else begin
                            // Flywheel: assume the marker was there and start the next codeblock
                            state_d     = FRAME;
                            bit_cnt_d   = '0;
                            lfsr_reseed = 1'b1;
                        end
                    end else begin
                        asm_cnt_d = asm_cnt_q + 5'd1;
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end
    end

    // State, counters and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= SEARCH;
            asm_sr_q      <= '0;
            bit_cnt_q     <= '0;
            asm_cnt_q     <= '0;
            miss_cnt_q    <= '0;
            data_q        <= 1'b0;
            data_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            asm_miss_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            asm_sr_q      <= asm_sr_d;
            bit_cnt_q     <= bit_cnt_d;
            asm_cnt_q     <= asm_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            data_q        <= data_d;
            data_valid_q  <= data_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            asm_miss_q    <= asm_miss_d;
        end
    end

    assign data_o        = data_q;
    assign data_valid_o  = data_valid_q;
    assign frame_start_o = frame_start_q;
    assign frame_end_o   = frame_end_q;
    assign asm_miss_o    = asm_miss_q;
    assign locked_o      = (state_q == FRAME) || (state_q == CHECK);

endmodule

// File: tb/tb_ccsds_frame_sync_derandomizer.sv
// tb/tb_ccsds_frame_sync_derandomizer.sv - self-checking bench with a positional reference model
module tb_ccsds_frame_sync_derandomizer;

    localparam int          FB       = 2040;
    localparam logic [31:0] ASM_W    = 32'h1ACFFC1D;
    localparam int          MAX_ERR  = 2;
    localparam int          MISS_LIM = 3;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic bit_i = 1'b0;
    logic bit_valid_i = 1'b0;
    logic data_o, data_valid_o, frame_start_o, frame_end_o, locked_o, asm_miss_o;

    int total = 0;
    int bad = 0;

    int gap_mode = 0;
    logic got[$];
    logic sent[$];
    int cnt_valid, cnt_start, cnt_end, cnt_miss, end_idx;
    bit pn[FB];

    always #5 clk = ~clk;

    ccsds_frame_sync_derandomizer dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .bit_i         (bit_i),
        .bit_valid_i   (bit_valid_i),
        .data_o        (data_o),
        .data_valid_o  (data_valid_o),
        .frame_start_o (frame_start_o),
        .frame_end_o   (frame_end_o),
        .locked_o      (locked_o),
        .asm_miss_o    (asm_miss_o)
    );

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_stats();
        got.delete();
        sent.delete();
        cnt_valid = 0;
        cnt_start = 0;
        cnt_end   = 0;
        cnt_miss  = 0;
        end_idx   = -1;
    endtask

    // Model: pos<0 searching, 0..FB-1 payload position, FB..FB+31 expected-marker window
    initial begin
        int pos;
        int miss;
        logic [31:0] msr, nsr, w;
        logic r, v, b, hit;
        logic e_data, e_valid, e_start, e_end, e_miss;
        pos = -1;
        miss = 0;
        msr = '0;
        for (int i = 0; i < 8; i++) pn[i] = 1'b1;
        for (int i = 8; i < FB; i++) pn[i] = pn[i-8] ^ pn[i-5] ^ pn[i-3] ^ pn[i-1];
        w = '0;
        for (int i = 0; i < 32; i++) w = {w[30:0], pn[i]};
        check("pn_model_head", w, 32'hFF480EC0);
        forever begin
            @(posedge clk);
            r = rst_i;
            v = bit_valid_i;
            b = bit_i;
            e_data = 1'b0; e_valid = 1'b0; e_start = 1'b0; e_end = 1'b0; e_miss = 1'b0;
            if (r) begin
                pos = -1;
                miss = 0;
                msr = '0;
            end else if (v) begin
                nsr = {msr[30:0], b};
                hit = ($countones(nsr ^ ASM_W) <= MAX_ERR);
                if (pos < 0) begin
                    if (hit) begin
                        pos = 0;
                        miss = 0;
                    end
                end else if (pos < FB) begin
                    e_valid = 1'b1;
                    e_data  = b ^ pn[pos];
                    e_start = (pos == 0);
                    e_end   = (pos == FB - 1);
                    pos++;
                end else begin
                    pos++;
                    if (pos == FB + 32) begin
                        if (hit) begin
                            miss = 0;
                            pos = 0;
                        end else begin
                            e_miss = 1'b1;
                            miss++;
                            pos = (miss == MISS_LIM) ? -1 : 0;
                        end
                    end
                end
                msr = nsr;
            end
            #3;
            check("data_valid", data_valid_o, e_valid);
            if (e_valid) check("data", data_o, e_data);
            check("frame_start", frame_start_o, e_start);
            check("frame_end", frame_end_o, e_end);
            check("asm_miss", asm_miss_o, e_miss);
            check("locked", locked_o, (pos >= 0));
            if (data_valid_o) begin
                got.push_back(data_o);
                cnt_valid++;
            end
            if (frame_start_o) cnt_start++;
            if (frame_end_o) begin
                cnt_end++;
                end_idx = cnt_valid;
            end
            if (asm_miss_o) cnt_miss++;
        end
    end

    task automatic drive(input logic r, input logic v, input logic b);
        @(posedge clk);
        #1;
        rst_i = r;
        bit_valid_i = v;
        bit_i = b;
    endtask

    task automatic send_bit(input logic b);
        int ng;
        ng = (gap_mode == 2) ? 3 : ((gap_mode == 1) ? int'($urandom_range(0, 2)) : 0);
        for (int i = 0; i < ng; i++) drive(1'b0, 1'b0, 1'($urandom));
        drive(1'b0, 1'b1, b);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0);
    endtask

    task automatic settle();
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        clear_stats();
    endtask

    task automatic flip_bits(input logic [31:0] w, input int n, output logic [31:0] o);
        int c;
        int p;
        o = w;
        c = 0;
        while (c < n) begin
            p = $urandom_range(0, 31);
            if (o[p] == w[p]) begin
                o[p] = ~o[p];
                c++;
            end
        end
    endtask

    // kind 0: all ones, kind 1: random; embed_at>=0 places the marker inside the payload
    task automatic send_payload(input int kind, input int embed_at, input int nbits);
        logic [31:0] asm_v;
        logic b;
        asm_v = ASM_W;
        for (int i = 0; i < nbits; i++) begin
            b = (kind == 0) ? 1'b1 : 1'($urandom);
            if (embed_at >= 0 && i >= embed_at && i < embed_at + 32) b = asm_v[31 - (i - embed_at)];
            sent.push_back(b);
            send_bit(b);
        end
    endtask

    function automatic logic [31:0] got_word(input int base);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 32; i++) w = {w[30:0], got[base + i]};
        return w;
    endfunction

    initial begin
        logic [31:0] bad_asm;
        logic [7:0] in_byte[3];
        logic [7:0] out_byte;
        clear_stats();

        // reset state
        do_reset();
        settle();
        check("reset_locked", locked_o, 0);
        check("reset_valid", data_valid_o, 0);
        check("reset_miss", asm_miss_o, 0);

        // clean frame of ones
        idle(40);
        send_word(ASM_W);
        send_payload(0, -1, FB);
        settle();
        check("clean_head", got_word(0), 32'h00B7F13F);
        check("clean_count", cnt_valid, FB);
        check("clean_starts", cnt_start, 1);
        check("clean_ends", cnt_end, 1);
        check("clean_end_idx", end_idx, FB);
        check("clean_locked", locked_o, 1);

        // marker tolerance
        do_reset();
        idle(40);
        flip_bits(ASM_W, 2, bad_asm);
        send_word(bad_asm);
        idle(64);
        settle();
        check("tol2_locked", locked_o, 1);
        check("tol2_count", cnt_valid, 64);
        do_reset();
        idle(40);
        flip_bits(ASM_W, 3, bad_asm);
        send_word(bad_asm);
        idle(64);
        settle();
        check("tol3_locked", locked_o, 0);
        check("tol3_count", cnt_valid, 0);

        // flywheel: miss, recover, then three misses in a row
        do_reset();
        gap_mode = 1;
        idle(16);
        send_word(ASM_W);
        send_payload(1, -1, FB);
        flip_bits(ASM_W, 3, bad_asm); send_word(bad_asm);
        send_payload(1, -1, FB);
        send_word(ASM_W);
        send_payload(1, -1, FB);
        flip_bits(ASM_W, 4, bad_asm); send_word(bad_asm);
        send_payload(1, -1, FB);
        flip_bits(ASM_W, 3, bad_asm); send_word(bad_asm);
        send_payload(1, -1, FB);
        flip_bits(ASM_W, 5, bad_asm); send_word(bad_asm);
        idle(100);
        settle();
        check("fly_misses", cnt_miss, 4);
        check("fly_count", cnt_valid, 5 * FB);
        check("fly_starts", cnt_start, 5);
        check("fly_locked", locked_o, 0);

        // back-to-back frames, one bit in four
        do_reset();
        gap_mode = 2;
        idle(8);
        send_word(ASM_W);
        for (int f = 0; f < 3; f++) begin
            sent.delete();
            send_payload(1, -1, FB);
            for (int i = 0; i < 8; i++) in_byte[f][7 - i] = sent[i];
            send_word(ASM_W);
        end
        settle();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) out_byte[7 - i] = got[f * FB + i];
            check("b2b_first_byte", out_byte, in_byte[f] ^ 8'hFF);
        end
        check("b2b_count", cnt_valid, 3 * FB);
        check("b2b_ends", cnt_end, 3);

        // reset in the middle of a frame with a bit offered in the same cycle
        do_reset();
        gap_mode = 0;
        idle(8);
        send_word(ASM_W);
        send_payload(1, -1, 1000);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        check("midrst_valid", data_valid_o, 0);
        check("midrst_locked", locked_o, 0);
        check("midrst_start", frame_start_o, 0);
        clear_stats();
        idle(8);
        send_word(ASM_W);
        send_payload(0, -1, FB);
        settle();
        check("relock_head", got_word(0), 32'h00B7F13F);
        check("relock_count", cnt_valid, FB);

        // marker pattern embedded in payload must not resync
        do_reset();
        idle(8);
        send_word(ASM_W);
        send_payload(1, 500, FB);
        settle();
        check("embed_ends", cnt_end, 1);
        check("embed_end_idx", end_idx, FB);
        check("embed_starts", cnt_start, 1);
        check("embed_locked", locked_o, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
